// File: rtl/aes_inv_sub_serial_if.sv
// rtl/aes_inv_sub_serial_if.sv - handshake and state-column bundle for aes_inv_sub_serial
//
// Purpose: groups the input handshake, the four input state columns, the
// output handshake, the four result columns and the busy flag.
// Signals:
//   in_valid / in_ready       : input state handshake
//   S_0..S_3 [WIDTH]          : state columns to be inverse-substituted
//   out_valid / out_ready     : result handshake
//   S_0_next..S_3_next [WIDTH]: registered InvSubBytes result
//   busy                      : operation in progress (SUB or DONE)
// Modports: slave = the substitution block, master = the source/sink side.
interface aes_inv_sub_serial_if #(
  parameter int WIDTH = 32
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] S_0;
  logic [WIDTH-1:0] S_1;
  logic [WIDTH-1:0] S_2;
  logic [WIDTH-1:0] S_3;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] S_0_next;
  logic [WIDTH-1:0] S_1_next;
  logic [WIDTH-1:0] S_2_next;
  logic [WIDTH-1:0] S_3_next;
  logic             busy;

  modport slave (
    input  in_valid, S_0, S_1, S_2, S_3, out_ready,
    output in_ready, out_valid, S_0_next, S_1_next, S_2_next, S_3_next, busy
  );

  modport master (
    output in_valid, S_0, S_1, S_2, S_3, out_ready,
    input  in_ready, out_valid, S_0_next, S_1_next, S_2_next, S_3_next, busy
  );
endinterface

// File: rtl/aes_inv_sub_serial.sv
// rtl/aes_inv_sub_serial.sv - byte-serial AES InvSubBytes over a 128-bit state
//
// Purpose: accepts a 128-bit state, substitutes its 16 bytes one per cycle
// through a single shared S-box in inverse mode, then presents the result
// until the sink takes it.
// Ports:
//   clk : clock, all state updates on the rising edge
//   rst : synchronous active-high reset
//   bus : aes_inv_sub_serial_if.slave (handshakes, state columns, busy)
// AES_sbox ports:
//   i_mode : 1 = inverse S-box, 0 = forward S-box
//   i_data : input byte
//   o_data : substituted byte

module AES_sbox (
  input  logic       i_mode,
  input  logic [7:0] i_data,
  output logic [7:0] o_data
);
  // Multiply by x modulo the AES polynomial x^8+x^4+x^3+x+1.
  function automatic logic [7:0] xtime(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] aa;
    p  = 8'h00;
    aa = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ aa;
      aa = xtime(aa);
    end
    return p;
  endfunction

  // Multiplicative inverse as a^254; 0 maps to 0 as AES requires.
  // The loop builds a^3, a^7, ... a^127, then one final squaring gives a^254.
  function automatic logic [7:0] gf_inv(input logic [7:0] a);
    logic [7:0] r;
    r = a;
    for (int i = 0; i < 6; i++) begin
      r = gf_mul(gf_mul(r, r), a);
    end
    return gf_mul(r, r);
  endfunction

  function automatic logic [7:0] rotl(input logic [7:0] b, input int n);
    logic [15:0] t;
    t = {b, b} << n;
    return t[15:8];
  endfunction

  logic [7:0] w_inv_aff;
  logic [7:0] w_fwd_inv;

  // Inverse: undo the affine map, then invert. Forward: invert, then affine.
  assign w_inv_aff = rotl(i_data, 1) ^ rotl(i_data, 3) ^ rotl(i_data, 6) ^ 8'h05;
  assign w_fwd_inv = gf_inv(i_data);

  always_comb begin
    o_data = 8'h00;
    if (i_mode) begin
      o_data = gf_inv(w_inv_aff);
    end else begin
      o_data = w_fwd_inv ^ rotl(w_fwd_inv, 1) ^ rotl(w_fwd_inv, 2) ^
               rotl(w_fwd_inv, 3) ^ rotl(w_fwd_inv, 4) ^ 8'h63;
    end
  end
endmodule

module aes_inv_sub_serial #(
  parameter int WIDTH = 32
) (
  input logic                 clk,
  input logic                 rst,
  aes_inv_sub_serial_if.slave bus
);
  localparam int STATE_W = 4 * WIDTH;

  typedef enum logic [1:0] {
    IDLE,
    SUB,
    DONE
  } state_t;

  state_t             r_state;
  state_t             w_next_state;
  logic [3:0]         r_cnt;
  logic [STATE_W-1:0] r_in;
  logic [STATE_W-1:0] r_out;
  logic [7:0]         w_sbox_in;
  logic [7:0]         w_sbox_out;
  logic               w_in_ready;
  logic               w_out_valid;
  logic               w_busy;

  // Byte cnt lives at bits [8*cnt +: 8], so S_0[7:0] is byte 0 and S_3[31:24] is byte 15.
  assign w_sbox_in = r_in[{r_cnt, 3'b000} +: 8];

  AES_sbox u_sbox (
    .i_mode (1'b1),
    .i_data (w_sbox_in),
    .o_data (w_sbox_out)
  );

  always_comb begin
    w_next_state = r_state;
    w_in_ready   = 1'b0;
    w_out_valid  = 1'b0;
    w_busy       = 1'b0;
    case (r_state)
      IDLE: begin
        w_in_ready = 1'b1;
        if (bus.in_valid) w_next_state = SUB;
      end
      SUB: begin
        w_busy = 1'b1;
        if (r_cnt == 4'd15) w_next_state = DONE;
      end
      DONE: begin
        w_busy      = 1'b1;
        w_out_valid = 1'b1;
        if (bus.out_ready) w_next_state = IDLE;
      end
      default: w_next_state = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
      r_cnt   <= 4'd0;
      r_in    <= '0;
      r_out   <= '0;
    end else begin
      r_state <= w_next_state;
      case (r_state)
        IDLE: begin
          if (bus.in_valid) begin
            r_in  <= {bus.S_3, bus.S_2, bus.S_1, bus.S_0};
            r_out <= '0;
            r_cnt <= 4'd0;
          end
        end
        SUB: begin
          r_out[{r_cnt, 3'b000} +: 8] <= w_sbox_out;
          // Wraps 15 -> 0 on the last byte, leaving cnt cleared for DONE.
          r_cnt <= r_cnt + 4'd1;
        end
        default: ;
      endcase
    end
  end

  assign bus.in_ready  = w_in_ready;
  assign bus.out_valid = w_out_valid;
  assign bus.busy      = w_busy;
  assign bus.S_0_next  = r_out[0*WIDTH +: WIDTH];
  assign bus.S_1_next  = r_out[1*WIDTH +: WIDTH];
  assign bus.S_2_next  = r_out[2*WIDTH +: WIDTH];
  assign bus.S_3_next  = r_out[3*WIDTH +: WIDTH];
endmodule

// File: tb/tb_aes_inv_sub_serial.sv
// tb/tb_aes_inv_sub_serial.sv - scoreboard bench for aes_inv_sub_serial
module tb_aes_inv_sub_serial;
  logic clk;
  logic rst;
  int   checks;
  int   failures;
  logic [127:0] exp_q[$];

  aes_inv_sub_serial_if #(.WIDTH(32)) bus ();

  aes_inv_sub_serial #(.WIDTH(32)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [127:0] result();
    return {bus.S_3_next, bus.S_2_next, bus.S_1_next, bus.S_0_next};
  endfunction

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Monitor: every completed output handshake pops and compares one expected result.
  always @(negedge clk) begin
    if (!rst && bus.out_valid === 1'b1 && bus.out_ready === 1'b1) begin
      checks++;
      if (exp_q.size() == 0) begin
        failures++;
        $display("FAIL unexpected_result actual=%h required=none", result());
      end else begin
        logic [127:0] e;
        e = exp_q.pop_front();
        if (result() !== e) begin
          failures++;
          $display("FAIL result actual=%h required=%h", result(), e);
        end
      end
    end
  end

  task automatic drive(input logic [127:0] s);
    bus.S_0 = s[31:0];
    bus.S_1 = s[63:32];
    bus.S_2 = s[95:64];
    bus.S_3 = s[127:96];
  endtask

  // Offer a state, wait for acceptance, optionally push its expected result.
  task automatic send(input logic [127:0] s, input logic [127:0] e, input bit push, input bit keep_valid);
    int n;
    drive(s);
    bus.in_valid = 1'b1;
    n = 0;
    while (bus.in_ready !== 1'b1 && n < 40) begin
      tick();
      n++;
    end
    if (n >= 40) chk("accept_timeout", 128'(n), 128'd0);
    if (push) exp_q.push_back(e);
    tick();
    if (!keep_valid) bus.in_valid = 1'b0;
  endtask

  // Count cycles after the accept edge until out_valid is seen.
  task automatic wait_out(input string name);
    int n;
    n = 0;
    while (bus.out_valid !== 1'b1 && n < 40) begin
      tick();
      n++;
    end
    chk(name, 128'(n), 128'd16);
  endtask

  localparam logic [127:0] VA_IN  = {4{32'h63636363}};
  localparam logic [127:0] VA_OUT = 128'd0;
  localparam logic [127:0] VB_IN  = {32'h7C7C7C7C, 32'h00000000, 32'h16161616, 32'h00007C63};
  localparam logic [127:0] VB_OUT = {32'h01010101, 32'h52525252, 32'hFFFFFFFF, 32'h52520100};
  localparam logic [127:0] VC_IN  = {32'h76ABD7FE, 32'h2B670130, 32'hC56F6BF2, 32'h7B777C63};
  localparam logic [127:0] VC_OUT = {32'h0F0E0D0C, 32'h0B0A0908, 32'h07060504, 32'h03020100};

  initial begin
    int seen;
    checks    = 0;
    failures  = 0;
    rst       = 1'b1;
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    drive(128'd0);
    tick();
    tick();
    rst = 1'b0;

    chk("reset_in_ready", 128'(bus.in_ready), 128'd1);
    chk("reset_out_valid", 128'(bus.out_valid), 128'd0);
    chk("reset_busy", 128'(bus.busy), 128'd0);
    chk("reset_result", result(), 128'd0);

    // Idle with in_valid low: S inputs ignored.
    for (int i = 0; i < 4; i++) begin
      drive({4{$urandom()}});
      tick();
    end
    chk("idle_hold_in_ready", 128'(bus.in_ready), 128'd1);
    chk("idle_hold_result", result(), 128'd0);

    // All-0x63 state with sink ready.
    send(VA_IN, VA_OUT, 1'b1, 1'b0);
    chk("busy_in_sub", 128'(bus.busy), 128'd1);
    wait_out("latency_a");
    tick();
    chk("pulse_out_valid", 128'(bus.out_valid), 128'd0);
    chk("return_in_ready", 128'(bus.in_ready), 128'd1);

    // Mixed-byte vector.
    send(VB_IN, VB_OUT, 1'b1, 1'b0);
    wait_out("latency_b");
    tick();
    chk("retain_result_b", result(), VB_OUT);

    // Byte-order vector with back-pressure and toggling inputs.
    bus.out_ready = 1'b0;
    send(VC_IN, VC_OUT, 1'b1, 1'b0);
    wait_out("latency_c");
    for (int i = 0; i < 10; i++) begin
      drive({$urandom(), $urandom(), $urandom(), $urandom()});
      bus.in_valid = i[0];
      tick();
      chk("hold_out_valid", 128'(bus.out_valid), 128'd1);
      chk("hold_in_ready", 128'(bus.in_ready), 128'd0);
      chk("hold_result", result(), VC_OUT);
    end
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    tick();
    chk("release_in_ready", 128'(bus.in_ready), 128'd1);
    chk("release_out_valid", 128'(bus.out_valid), 128'd0);

    // Abort with reset while cnt = 7.
    send(VB_IN, VB_OUT, 1'b0, 1'b0);
    for (int i = 0; i < 7; i++) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("abort_in_ready", 128'(bus.in_ready), 128'd1);
    chk("abort_busy", 128'(bus.busy), 128'd0);
    chk("abort_result", result(), 128'd0);
    seen = 0;
    for (int i = 0; i < 20; i++) begin
      if (bus.out_valid === 1'b1) seen++;
      tick();
    end
    chk("abort_no_out_valid", 128'(seen), 128'd0);
    send(VA_IN, VA_OUT, 1'b1, 1'b0);
    wait_out("latency_after_abort");
    tick();

    // Back-to-back offers with in_valid held high.
    send(VC_IN, VC_OUT, 1'b1, 1'b1);
    drive(VB_IN);
    wait_out("latency_b2b_first");
    tick();
    chk("b2b_in_ready_next", 128'(bus.in_ready), 128'd1);
    exp_q.push_back(VB_OUT);
    tick();
    bus.in_valid = 1'b0;
    chk("b2b_second_busy", 128'(bus.busy), 128'd1);
    wait_out("latency_b2b_second");
    tick();

    chk("queue_drained", 128'(exp_q.size()), 128'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/aes_inv_sub_serial.md
AES_INV_SUB_SERIAL -- requirements
Module: AES_INV_SUB_SERIAL

Interface
REQ-001 Parameter: WIDTH, default 32, width of each state column word; only 32 is supported.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst  input  1  synchronous, active-high reset.
REQ-004 in_valid  input  1  source presents a 128-bit state on S_0..S_3.
REQ-005 in_ready  output  1  block can accept a state this cycle.
REQ-006 S_0, S_1, S_2, S_3  input  WIDTH each  state columns to be inverse-substituted.
REQ-007 out_valid  output  1  S_0_next..S_3_next hold a completed result.
REQ-008 out_ready  input  1  sink accepts the result this cycle.
REQ-009 S_0_next, S_1_next, S_2_next, S_3_next  output  WIDTH each  registered InvSubBytes result.
REQ-010 busy  output  1  high in SUB or DONE state.

Function
REQ-011 The block SHALL compute InvSubBytes byte-serially using exactly one AES_sbox instance with mode tied to the inverse-select value (1'b1).
REQ-012 FSM states SHALL be IDLE, SUB, DONE; encoding free.
REQ-013 in_ready SHALL be 1 only in IDLE; out_valid SHALL be 1 only in DONE; busy = SUB or DONE.
REQ-014 IDLE: on in_valid && in_ready, capture S_0..S_3 into an internal 128-bit input register, clear all output registers to 0, clear 4-bit byte counter to 0, go to SUB.
REQ-015 IDLE with in_valid=0: no state change; S_x inputs ignored.
REQ-016 SUB: each cycle feed byte[cnt] of the captured state to the sbox and write the sbox result into the same byte position of the output registers; cnt increments by 1.
REQ-017 Byte order: cnt 0..3 = S_0[7:0], [15:8], [23:16], [31:24]; cnt 4..7 = S_1 likewise; cnt 8..11 = S_2; cnt 12..15 = S_3.
REQ-018 SUB with cnt=15: write final byte, cnt wraps to 0, go to DONE.
REQ-019 Latency: accept handshake on edge k; out_valid SHALL first be observed 1 after edge k+16, with all 16 bytes valid.
REQ-020 DONE: S_x_next SHALL hold stable while out_valid=1 and out_ready=0, for any number of cycles.
REQ-021 DONE with out_ready=1: go to IDLE; in_ready=1 in the following cycle; output registers retain the last result.
REQ-022 in_valid during SUB/DONE SHALL be ignored (no capture, no corruption); source must hold until in_ready.
REQ-023 No back-to-back throughput: minimum 18 cycles between successive accepts (accept, 16 SUB, DONE handshake).
REQ-024 The captured input register SHALL not change between accept and return to IDLE, regardless of S_x input activity.

Reset
REQ-025 rst=1 at a rising edge SHALL force IDLE, cnt=0, input register=0, S_0_next..S_3_next=0, out_valid=0, busy=0, in_ready=1 after that edge.
REQ-026 rst SHALL take priority over every handshake in the same cycle, including in_valid&&in_ready and out_valid&&out_ready.
REQ-027 rst asserted mid-SUB or in DONE SHALL abort the operation; no partial result is presented afterwards.

Verification
REQ-028 After reset: in_ready=1, out_valid=0, busy=0, all S_x_next=0 -> held until first accept.
REQ-029 Accept S_0=S_1=S_2=S_3=32'h63636363, out_ready=1 -> out_valid rises after 16th edge post-accept, all S_x_next=32'h00000000, one-cycle out_valid pulse, in_ready=1 next cycle.
REQ-030 Accept S_0=32'h00007C63, S_1=32'h16161616, S_2=32'h00000000, S_3=32'h7C7C7C7C -> S_0_next=32'h52520100, S_1_next=32'hFFFFFFFF, S_2_next=32'h52525252, S_3_next=32'h01010101.
REQ-031 Result ready with out_ready=0 for 10 cycles while S_x inputs and in_valid toggle -> out_valid and S_x_next unchanged, in_ready=0; releasing out_ready returns to IDLE in 1 cycle.
REQ-032 rst pulsed at cnt=7 of an operation -> next cycle IDLE, outputs all 0, out_valid never asserts for the aborted state; subsequent accept of 32'h63636363 x4 completes normally.
REQ-033 Two states offered back-to-back with in_valid held high -> second accepted exactly one cycle after the first DONE handshake; results correct and in order.
